// File: rtl/tlb_cmd_unit.sv
// Joint MIPS-style TLB: cp0 command/response port, combinational search
// ports, hardware Random/Wired and a sequential invalidate sweep.
module tlb_cmd_unit #(
   parameter  int TLBNUM      = 16,
   parameter  int NSEARCH     = 2,
   parameter  int WIRED_RESET = 0,
   localparam int IDXW        = $clog2(TLBNUM)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [19*NSEARCH-1:0]   s_vpn2,
   input  logic [NSEARCH-1:0]      s_odd,
   input  logic [8*NSEARCH-1:0]    s_asid,
   output logic [NSEARCH-1:0]      s_found,
   output logic [IDXW*NSEARCH-1:0] s_index,
   output logic [20*NSEARCH-1:0]   s_pfn,
   output logic [5*NSEARCH-1:0]    s_cdv,
   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic [1:0]              cmd_op,
   input  logic [IDXW-1:0]         cmd_index,
   input  logic [77:0]             cmd_entry,
   output logic                    resp_valid,
   output logic                    resp_found,
   output logic [IDXW-1:0]         resp_index,
   output logic [77:0]             resp_entry,
   input  logic                    wired_we,
   input  logic [IDXW-1:0]         wired_wdata,
   output logic [IDXW-1:0]         random,
   output logic [IDXW-1:0]         wired,
   input  logic                    inv_req,
   input  logic                    inv_mode,
   input  logic [7:0]              inv_asid,
   output logic                    inv_busy,
   output logic                    inv_done
);

   localparam logic [IDXW-1:0] LAST = IDXW'(TLBNUM-1);

   typedef enum logic {IDLE, SWEEP} state_e;

   state_e          state_q;
   logic [77:0]     ent_q [TLBNUM];
   logic [IDXW-1:0] ptr_q;
   logic [IDXW-1:0] random_q;
   logic [IDXW-1:0] wired_q;
   logic            inv_mode_q;
   logic [7:0]      inv_asid_q;
   logic            inv_busy_q;
   logic            inv_done_q;
   logic            resp_valid_q;
   logic            resp_found_q;
   logic [IDXW-1:0] resp_index_q;
   logic [77:0]     resp_entry_q;

   logic            acc;
   logic            p_found;
   logic [IDXW-1:0] p_idx;
   logic            sw_hit;

   // Entry layout: vpn2 77:59, asid 58:51, g 50, even page 49:25, odd 24:0
   function automatic logic match(input logic [77:0] e,
                                  input logic [18:0] vpn2,
                                  input logic [7:0]  asid);
      return (e[77:59] == vpn2) && (e[50] || (e[58:51] == asid));
   endfunction

   for (genvar k = 0; k < NSEARCH; k++) begin : g_srch
      logic            hit;
      logic [IDXW-1:0] idx;
      logic [77:0]     e;

      // Descending scan so the lowest matching index is left last
      always_comb begin
         hit = 1'b0;
         idx = '0;
         for (int i = TLBNUM-1; i >= 0; i--) begin
            if (match(ent_q[i], s_vpn2[19*k +: 19], s_asid[8*k +: 8])) begin
               hit = 1'b1;
               idx = IDXW'(i);
            end
         end
      end

      assign e = ent_q[idx];
      assign s_found[k] = hit;
      assign s_index[IDXW*k +: IDXW] = idx;
      assign s_pfn[20*k +: 20] = !hit ? 20'd0 :
                                 s_odd[k] ? e[24:5] : e[49:30];
      assign s_cdv[5*k +: 5] = !hit ? 5'd0 :
                               s_odd[k] ? e[4:0] : e[29:25];
   end

   always_comb begin
      p_found = 1'b0;
      p_idx   = '0;
      for (int i = TLBNUM-1; i >= 0; i--) begin
         if (match(ent_q[i], cmd_entry[77:59], cmd_entry[58:51])) begin
            p_found = 1'b1;
            p_idx   = IDXW'(i);
         end
      end
   end

   assign cmd_ready = (state_q == IDLE) && !inv_req;
   assign acc       = cmd_valid && cmd_ready;
   assign sw_hit    = !inv_mode_q ||
                      (!ent_q[ptr_q][50] && (ent_q[ptr_q][58:51] == inv_asid_q));

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         ptr_q        <= '0;
         random_q     <= LAST;
         wired_q      <= IDXW'(WIRED_RESET);
         inv_mode_q   <= 1'b0;
         inv_asid_q   <= '0;
         inv_busy_q   <= 1'b0;
         inv_done_q   <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_found_q <= 1'b0;
         resp_index_q <= '0;
         resp_entry_q <= '0;
         for (int i = 0; i < TLBNUM; i++) ent_q[i] <= '0;
      end else begin
         inv_done_q   <= 1'b0;
         resp_valid_q <= acc;
         resp_found_q <= 1'b0;
         resp_index_q <= '0;
         resp_entry_q <= '0;

         if (acc) begin
            unique case (cmd_op)
               2'd0: begin
                  resp_found_q <= p_found;
                  resp_index_q <= p_idx;
               end
               2'd1: resp_entry_q <= ent_q[cmd_index];
               2'd2: ent_q[cmd_index] <= cmd_entry;
               2'd3: begin
                  ent_q[random_q] <= cmd_entry;
                  resp_index_q    <= random_q;
               end
            endcase
         end

         unique case (state_q)
            IDLE: begin
               if (inv_req) begin
                  state_q    <= SWEEP;
                  inv_busy_q <= 1'b1;
                  inv_mode_q <= inv_mode;
                  inv_asid_q <= inv_asid;
                  ptr_q      <= '0;
               end
            end
            SWEEP: begin
               if (sw_hit) begin
                  ent_q[ptr_q][25] <= 1'b0;
                  ent_q[ptr_q][0]  <= 1'b0;
               end
               ptr_q <= ptr_q + 1'b1;
               if (ptr_q == LAST) begin
                  state_q    <= IDLE;
                  inv_busy_q <= 1'b0;
                  inv_done_q <= 1'b1;
               end
            end
         endcase

         if (wired_we) begin
            wired_q  <= wired_wdata;
            random_q <= LAST;
         end else if ((wired_q >= LAST) || (random_q <= wired_q)) begin
            random_q <= LAST;
         end else begin
            random_q <= random_q - 1'b1;
         end
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_found = resp_found_q;
   assign resp_index = resp_index_q;
   assign resp_entry = resp_entry_q;
   assign random     = random_q;
   assign wired      = wired_q;
   assign inv_busy   = inv_busy_q;
   assign inv_done   = inv_done_q;

endmodule
